kernel_share_arb: RTL
=====================

# kernel_share_arb

Round-robin arbiter and scheduler that shares one streaming kernel datapath between NREQ independent requester streams. Grants the kernel input to one requester at a time in bursts, records a requester tag for every word issued, and routes each kernel output word back to the requester that issued it. Sits between the stream sources/sinks and a single instantiated valid/ready kernel pipeline of arbitrary, unknown latency.

## Interface
- STREAMW, 34, data width of every stream word
- NREQ, 2, number of requesters (2..4)
- BURST, 8, maximum consecutive words issued per grant (1..255)
- TAGD, 16, tag FIFO depth (power of two), i.e. maximum words in flight in the kernel

- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req_valid  in  NREQ  per-requester input valid
- req_data  in  NREQ*STREAMW  requester i owns bits [i*STREAMW +: STREAMW]
- req_ready  out  NREQ  per-requester input ready
- k_ivalid  out  1  valid to kernel input
- k_idata  out  STREAMW  data to kernel input
- k_iready  in  1  kernel input ready; independent of k_ivalid
- k_ovalid  in  1  kernel output valid
- k_odata  in  STREAMW  kernel output data
- k_oready  out  1  ready to kernel output
- rsp_valid  out  NREQ  per-requester response valid (one-hot or zero)
- rsp_data  out  STREAMW  response data, shared by all requesters
- rsp_ready  in  NREQ  per-requester response ready
- busy  out  1  grant held or words in flight
- inflight  out  $clog2(TAGD+1)  current tag FIFO occupancy
- err_orphan  out  1  sticky: kernel produced output with no tag outstanding
- stat_issued  out  NREQ*16  per-requester issued-word counters (see Configuration)

## Operation
- FSM states IDLE, LOCKED; registers grant (id), rr_ptr, burst_cnt.
- IDLE: scan requesters from rr_ptr upward (wrapping); first with req_valid high becomes grant; go LOCKED, burst_cnt=0. None valid: stay IDLE.
- LOCKED: issue = req_valid[grant] & k_iready & !full. k_ivalid = req_valid[grant] & !full; k_idata = slice[grant]; req_ready[grant] = k_iready & !full; all other req_ready 0.
- On issue: push grant into tag FIFO; burst_cnt+1. If burst_cnt==BURST-1 on issue, release.
- If req_valid[grant] is low in a LOCKED cycle, release (no issue that cycle).
- Release: rr_ptr = grant+1 mod NREQ, go IDLE. A lone active requester is regranted after one IDLE cycle.
- Return path: head = tag FIFO head. k_oready = !empty & rsp_ready[head]; rsp_valid[head] = !empty & k_ovalid; rsp_data = k_odata. Pop on k_ovalid & k_oready.
- Full: push blocked when full at cycle start, even if a pop occurs the same cycle. Simultaneous push and pop when not full: occupancy unchanged.
- Empty with k_ovalid high: k_oready stays 0, no response, err_orphan set until rst.
- Responses are in issue order; per-requester ordering preserved.

## Timing
- Reset values: state IDLE, rr_ptr 0, grant 0, burst_cnt 0, FIFO empty; req_ready, k_ivalid, k_oready, rsp_valid 0; busy 0, inflight 0, err_orphan 0, stat_issued 0.
- Grant latency: req_valid high in cycle n while IDLE -> LOCKED in n+1; first issue possible in n+1.
- Issue path combinational from req_valid/k_iready; return path combinational from k_ovalid/rsp_ready; no added latency beyond the kernel's.
- Full-throughput: one word per cycle during a burst; one dead cycle per grant change.
- rst mid-burst: all state cleared next edge; in-flight words are discarded by the integrator (kernel reset together).
- inflight, busy registered-state derived (no combinational dependence on inputs).

## Configuration
- KSHARE_STATS_EN defined: stat_issued[i] is a 16-bit counter incremented on each issue from requester i, wraps 0xFFFF->0, cleared by rst.
- Not defined: counters not built; stat_issued tied to 0.

## Test plan
- Single requester 0, kernel always ready, 20 words -> bursts of 8,8,4 with one idle cycle between, responses all on rsp_valid[0] in order.
- Requesters 0 and 1 continuously valid, BURST=8 -> grant alternates 0,1,0,1 in 8-word bursts; rr_ptr honored after reset (0 first).
- Kernel output stalled (rsp_ready low) until 16 words issued -> issue stops at inflight=16, req_ready 0; one pop then restores exactly one issue.
- Requester 1 drops valid after 3 words of its grant -> release, requester 0 granted next; 3 responses routed to requester 1.
- k_ovalid pulsed with FIFO empty -> no rsp_valid, k_oready 0, err_orphan 1 until rst.
- With KSHARE_STATS_EN, 70000 issues on requester 0 -> stat_issued[0] = 4464 (wrapped); without, 0.

Source files
------------

// File: rtl/kernel_share_arb.sv
// Round-robin burst arbiter sharing one valid/ready kernel between NREQ streams,
// with a tag FIFO routing kernel outputs back. Optional counters: KSHARE_STATS_EN.
module kernel_share_arb #(
    parameter int STREAMW = 34,
    parameter int NREQ    = 2,
    parameter int BURST   = 8,
    parameter int TAGD    = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NREQ-1:0]            req_valid,
    input  logic [NREQ*STREAMW-1:0]    req_data,
    output logic [NREQ-1:0]            req_ready,
    output logic                       k_ivalid,
    output logic [STREAMW-1:0]         k_idata,
    input  logic                       k_iready,
    input  logic                       k_ovalid,
    input  logic [STREAMW-1:0]         k_odata,
    output logic                       k_oready,
    output logic [NREQ-1:0]            rsp_valid,
    output logic [STREAMW-1:0]         rsp_data,
    input  logic [NREQ-1:0]            rsp_ready,
    output logic                       busy,
    output logic [$clog2(TAGD+1)-1:0]  inflight,
    output logic                       err_orphan,
    output logic [NREQ*16-1:0]         stat_issued
);

    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int PW  = $clog2(TAGD);
    localparam int CW  = $clog2(TAGD + 1);
    localparam int BW  = 8;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [IDW-1:0]   grant;
    logic [IDW-1:0]   grant_nxt;
    logic [IDW-1:0]   rr_ptr;
    logic [IDW-1:0]   rr_ptr_nxt;
    logic [IDW-1:0]   grant_inc;
    logic [BW-1:0]    burst_cnt;
    logic [BW-1:0]    burst_cnt_nxt;

    logic             scan_found;
    logic [IDW-1:0]   scan_pick;

    logic [STREAMW-1:0] req_word [NREQ];

    logic [IDW-1:0]   tag_mem [TAGD];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             full;
    logic             empty;
    logic             issue;
    logic             pop;
    logic [IDW-1:0]   head;

    for (genvar g = 0; g < NREQ; g++) begin : g_slice
        assign req_word[g] = req_data[g*STREAMW +: STREAMW];
    end

    assign grant_inc = (grant == IDW'(NREQ - 1)) ? '0 : grant + 1'b1;

    // Round-robin scan: walk offsets downward so the nearest valid requester
    // at or after rr_ptr is the last (winning) assignment.
    always_comb begin
        int idx;
        scan_found = 1'b0;
        scan_pick  = '0;
        idx        = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (req_valid[idx]) begin
                scan_found = 1'b1;
                scan_pick  = IDW'(idx);
            end
        end
    end

    // Grant FSM and issue path
    always_comb begin
        state_nxt     = state;
        grant_nxt     = grant;
        rr_ptr_nxt    = rr_ptr;
        burst_cnt_nxt = burst_cnt;
        req_ready     = '0;
        k_ivalid      = 1'b0;
        k_idata       = req_word[grant];
        issue         = 1'b0;
        case (state)
            IDLE: begin
                if (scan_found) begin
                    state_nxt     = LOCKED;
                    grant_nxt     = scan_pick;
                    burst_cnt_nxt = '0;
                end
            end
            LOCKED: begin
                k_ivalid         = req_valid[grant] & ~full;
                req_ready[grant] = k_iready & ~full;
                issue            = req_valid[grant] & k_iready & ~full;
                if (!req_valid[grant]) begin
                    state_nxt  = IDLE;
                    rr_ptr_nxt = grant_inc;
                end else if (issue) begin
                    burst_cnt_nxt = burst_cnt + 1'b1;
                    if (burst_cnt == BW'(BURST - 1)) begin
                        state_nxt  = IDLE;
                        rr_ptr_nxt = grant_inc;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            grant     <= '0;
            rr_ptr    <= '0;
            burst_cnt <= '0;
        end else begin
            state     <= state_nxt;
            grant     <= grant_nxt;
            rr_ptr    <= rr_ptr_nxt;
            burst_cnt <= burst_cnt_nxt;
        end
    end

    // Tag FIFO: full is judged on the registered count, so a same-cycle pop
    // never makes room for a push.
    assign full  = (count == CW'(TAGD));
    assign empty = (count == '0);
    assign head  = tag_mem[rd_ptr];
    assign pop   = k_ovalid & k_oready;

    always_ff @(posedge clk) begin
        if (issue) tag_mem[wr_ptr] <= grant;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            err_orphan <= 1'b0;
        end else begin
            if (issue) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            if (issue && !pop) begin
                count <= count + 1'b1;
            end else if (!issue && pop) begin
                count <= count - 1'b1;
            end
            if (k_ovalid && empty) err_orphan <= 1'b1;
        end
    end

    // Return path routed by the oldest outstanding tag
    always_comb begin
        rsp_valid = '0;
        k_oready  = ~empty & rsp_ready[head];
        if (!empty) rsp_valid[head] = k_ovalid;
    end

    assign rsp_data = k_odata;
    assign busy     = (state == LOCKED) | ~empty;
    assign inflight = count;

`ifdef KSHARE_STATS_EN
    logic [15:0] stat_cnt [NREQ];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREQ; i++) stat_cnt[i] <= '0;
        end else if (issue) begin
            stat_cnt[grant] <= stat_cnt[grant] + 16'd1;
        end
    end

    for (genvar g = 0; g < NREQ; g++) begin : g_stat
        assign stat_issued[g*16 +: 16] = stat_cnt[g];
    end
`else
    assign stat_issued = '0;
`endif

endmodule
